fifo_rr_scheduler: RTL and testbench
====================================

FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 12, giving the width of each FIFO data word.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the transfer counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Enable, input, 1 bit: when 1, the scheduler advances; when 0, it freezes.
REQ-006 The block SHALL have port fifo_empty, input, 4 bits: per-channel FIFO empty flags.
REQ-007 The block SHALL have port fifo_almost_full, input, 4 bits: per-channel FIFO almost-full flags.
REQ-008 The block SHALL have port fifo_data, input, 4*DATA_WIDTH bits: channel n data at bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port read_enable, output, 4 bits: one-hot per-channel FIFO read strobe.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the current word.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data and out_channel hold a valid word.
REQ-012 The block SHALL have port out_data, output, DATA_WIDTH bits: the captured FIFO word.
REQ-013 The block SHALL have port out_channel, output, 2 bits: the source channel index of out_data.
REQ-014 The block SHALL have port xfer_count, output, CNT_WIDTH bits: the number of completed transfers, wrapping modulo 2^CNT_WIDTH.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, READ, CAPTURE and HOLD.
REQ-016 In IDLE with Enable=1, if any fifo_empty bit is 0, the FSM SHALL register grant index g and move to READ; otherwise it SHALL stay in IDLE.
REQ-017 Grant selection SHALL search channels rr_ptr, rr_ptr+1, ... (mod 4) and pick the first non-empty channel.
REQ-018 After each grant, rr_ptr SHALL be updated to (g+1) mod 4.
REQ-019 In READ, read_enable SHALL equal one-hot(g) for exactly one cycle, and the FSM SHALL move to CAPTURE; all other cycles SHALL drive read_enable = 0.
REQ-020 In CAPTURE, the block SHALL register fifo_data channel g into out_data, set out_channel = g and out_valid = 1, and move to HOLD, giving one-cycle FIFO read latency.
REQ-021 In HOLD, out_data, out_channel and out_valid SHALL remain stable until out_ready = 1.
REQ-022 In HOLD, when out_ready = 1, the block SHALL clear out_valid, increment xfer_count and return to IDLE on the same edge.
REQ-023 The minimum period is 4 cycles per word, and grants SHALL be issued only from IDLE.
REQ-024 fifo_empty SHALL be sampled only in IDLE; changes in READ, CAPTURE or HOLD SHALL be ignored.
REQ-025 With Enable=0, all registers SHALL hold and read_enable SHALL be 0; resuming SHALL continue from the frozen state.
REQ-026 xfer_count SHALL wrap from 2^CNT_WIDTH-1 to 0 without a flag.

Reset
REQ-027 When Reset=1 at a clk edge, the block SHALL set state = IDLE, rr_ptr = 0, read_enable = 0, out_valid = 0, out_data = 0, out_channel = 0 and xfer_count = 0.
REQ-028 Reset SHALL take priority over Enable.
REQ-029 Reset in any non-IDLE state SHALL discard the in-flight word without counting it.

Configuration
REQ-030 Macro AF_PRIORITY_EN SHALL select between two grant policies.
REQ-031 With AF_PRIORITY_EN defined, in IDLE, if any channel has fifo_almost_full = 1 and fifo_empty = 0, the grant SHALL go to the lowest-index such channel, overriding round robin, with rr_ptr still updated per REQ-018.
REQ-032 Without AF_PRIORITY_EN, fifo_almost_full SHALL be ignored and the grant SHALL be pure round robin per REQ-017.

Verification
REQ-033 Bench SHALL drive Reset=1 for 2 cycles with all inputs active, and SHALL check all outputs = 0, state IDLE and no read_enable.
REQ-034 Bench SHALL drive fifo_empty=4'b0000, out_ready=1 and Enable=1 for 16 cycles, and SHALL check the out_channel sequence 0,1,2,3 with xfer_count = 4.
REQ-035 Bench SHALL drive only channel 2 non-empty with data 12'hA5C, and SHALL check read_enable = 4'b0100 on cycle 2 only and out_data = 12'hA5C, out_channel = 2 on cycle 3.
REQ-036 Bench SHALL hold out_ready = 0 for 10 cycles in HOLD, and SHALL check out_valid and out_data stable, read_enable = 0 and xfer_count unchanged; it SHALL then pulse out_ready and check xfer_count +1.
REQ-037 With AF_PRIORITY_EN, rr_ptr = 0, all channels non-empty and fifo_almost_full = 4'b1000, the bench SHALL check grant = 3 and then rr_ptr = 0; without the macro it SHALL check grant = 0.
REQ-038 Bench SHALL assert Reset during CAPTURE and drop Enable during READ, and SHALL check the discarded word, unchanged xfer_count, and the frozen state resuming correctly.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: four-channel FIFO drain scheduler with a round-robin grant,
// one-cycle FIFO read latency and a valid/ready output stage.
// Optional feature: define AF_PRIORITY_EN to let almost-full channels pre-empt
// the round-robin order (lowest index wins); the pointer still advances past
// whichever channel was granted.
module fifo_rr_scheduler #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic [3:0]              fifo_empty,
    input  logic [3:0]              fifo_almost_full,
    input  logic [4*DATA_WIDTH-1:0] fifo_data,
    output logic [3:0]              read_enable,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [1:0]              out_channel,
    output logic [CNT_WIDTH-1:0]    xfer_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                r_state,       w_state_nxt;
    logic [1:0]            r_rr_ptr,      w_rr_ptr_nxt;
    logic [1:0]            r_grant,       w_grant_nxt;
    logic                  r_out_valid,   w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_data,    w_out_data_nxt;
    logic [1:0]            r_out_channel, w_out_channel_nxt;
    logic [CNT_WIDTH-1:0]  r_xfer_count,  w_xfer_count_nxt;

    logic [1:0]            w_idx;
    logic [1:0]            w_rr_grant;
    logic                  w_rr_found;
    logic [1:0]            w_sel_grant;

    // Round-robin search: first non-empty channel starting at the pointer
    always_comb begin
        w_idx      = '0;
        w_rr_grant = r_rr_ptr;
        w_rr_found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_idx = r_rr_ptr + 2'(i);
            if (!w_rr_found && !fifo_empty[w_idx]) begin
                w_rr_grant = w_idx;
                w_rr_found = 1'b1;
            end
        end
    end

`ifdef AF_PRIORITY_EN
    logic [3:0] w_af_req;
    logic       w_af_found;
    logic [1:0] w_af_grant;

    // Almost-full override: lowest-index non-empty almost-full channel wins
    always_comb begin
        w_af_req   = fifo_almost_full & ~fifo_empty;
        w_af_found = 1'b0;
        w_af_grant = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!w_af_found && w_af_req[i]) begin
                w_af_grant = 2'(i);
                w_af_found = 1'b1;
            end
        end
        w_sel_grant = w_af_found ? w_af_grant : w_rr_grant;
    end
`else
    logic w_unused_af;

    assign w_sel_grant = w_rr_grant;
    assign w_unused_af = ^fifo_almost_full;
`endif

    // Next-state and output decode; Enable low freezes everything and masks the strobe
    always_comb begin
        w_state_nxt       = r_state;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_grant_nxt       = r_grant;
        w_out_valid_nxt   = r_out_valid;
        w_out_data_nxt    = r_out_data;
        w_out_channel_nxt = r_out_channel;
        w_xfer_count_nxt  = r_xfer_count;
        read_enable       = '0;
        if (Enable) begin
            case (r_state)
                IDLE: begin
                    if (w_rr_found) begin
                        w_grant_nxt  = w_sel_grant;
                        w_rr_ptr_nxt = w_sel_grant + 2'd1;
                        w_state_nxt  = READ;
                    end
                end
                READ: begin
                    read_enable = 4'b0001 << r_grant;
                    w_state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    w_out_data_nxt    = fifo_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
                    w_out_channel_nxt = r_grant;
                    w_out_valid_nxt   = 1'b1;
                    w_state_nxt       = HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        w_out_valid_nxt  = 1'b0;
                        w_xfer_count_nxt = r_xfer_count + 1'b1;
                        w_state_nxt      = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers; reset discards any in-flight word
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            r_xfer_count  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_channel <= w_out_channel_nxt;
            r_xfer_count  <= w_xfer_count_nxt;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;
    assign xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler. Expected words are queued from a reference grant
// model when stimulus is applied and popped when the DUT hands a word over.
// A narrow transfer counter is used so the wrap can be reached quickly.
module tb_fifo_rr_scheduler;

    localparam int DW = 12;
    localparam int CW = 4;

`ifdef AF_PRIORITY_EN
    localparam logic [3:0] AF_FIRST_RE  = 4'b1000;
    localparam logic [3:0] AF_SECOND_RE = 4'b0001;
`else
    localparam logic [3:0] AF_FIRST_RE  = 4'b0001;
    localparam logic [3:0] AF_SECOND_RE = 4'b0010;
`endif

    logic          clk = 1'b0;
    logic          Reset, Enable, out_ready;
    logic [3:0]    fifo_empty, fifo_almost_full;
    logic [DW-1:0] dat [4];
    logic [4*DW-1:0] fifo_data;
    logic [3:0]    read_enable;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_channel;
    logic [CW-1:0] xfer_count;

    always #5 clk = ~clk;

    assign fifo_data = {dat[3], dat[2], dat[1], dat[0]};

    fifo_rr_scheduler #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .Enable           (Enable),
        .fifo_empty       (fifo_empty),
        .fifo_almost_full (fifo_almost_full),
        .fifo_data        (fifo_data),
        .read_enable      (read_enable),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_channel      (out_channel),
        .xfer_count       (xfer_count)
    );

    typedef struct packed {
        logic [1:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    exp_t       sb[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] m_rr;
    int         m_count;

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    // Reference grant: optional almost-full override, then round-robin from rr
    function automatic logic [1:0] model_grant(input logic [3:0] empty, input logic [1:0] rr);
        logic [1:0] c;
`ifdef AF_PRIORITY_EN
        for (int i = 0; i < 4; i++)
            if (fifo_almost_full[i] && !empty[i]) return 2'(i);
`endif
        for (int k = 0; k < 4; k++) begin
            c = rr + 2'(k);
            if (!empty[c]) return c;
        end
        return rr;
    endfunction

    task automatic push_grant();
        exp_t e;
        e.ch   = model_grant(fifo_empty, m_rr);
        e.data = dat[e.ch];
        sb.push_back(e);
        m_rr = e.ch + 2'd1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Enable = 1'b1; out_ready = 1'b1;
        fifo_empty = '0; fifo_almost_full = '1;
        for (int n = 0; n < 4; n++) dat[n] = 12'hFFF;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (read_enable !== 4'b0) begin tests_failed++; $display("FAIL reset_re: got %b expected 0000", read_enable); end
        end
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_channel !== 2'd0 || xfer_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_outs: got v=%b d=%h ch=%0d cnt=%0d expected all 0", out_valid, out_data, out_channel, xfer_count);
        end
        Reset = 1'b0; fifo_empty = '1; fifo_almost_full = '0;
        m_rr = 2'd0; m_count = 0; sb.delete();
        @(negedge clk);
        tests_run++;
        if (read_enable !== 4'b0 || out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_idle: got re=%b v=%b expected 0000 0", read_enable, out_valid);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [3:0] exp_re;
        fifo_empty = '0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h100 + n);
        repeat (4) push_grant();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_re = ((k % 4) == 1 && sb.size() != 0) ? oh(sb[0].ch) : 4'b0;
            tests_run++;
            if (read_enable !== exp_re) begin tests_failed++; $display("FAIL rr_re k=%0d: got %b expected %b", k, read_enable, exp_re); end
            tests_run++;
            if (out_valid !== ((k % 4) == 3)) begin tests_failed++; $display("FAIL rr_valid k=%0d: got %b expected %b", k, out_valid, (k % 4) == 3); end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                tests_run++;
                if (out_channel !== e.ch || out_data !== e.data) begin
                    tests_failed++; $display("FAIL rr_word: got ch=%0d d=%h expected ch=%0d d=%h", out_channel, out_data, e.ch, e.data);
                end
                m_count++;
                if (k == 15) fifo_empty = '1;
            end
        end
        tests_run++;
        if (xfer_count !== CW'(4) || sb.size() != 0) begin
            tests_failed++; $display("FAIL rr_count: got cnt=%0d left=%0d expected 4 0", xfer_count, sb.size());
        end
    endtask

    task automatic test_single_channel();
        exp_t e;
        fifo_empty = 4'b1011; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'h111;
        dat[2] = 12'hA5C;
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== 4'b0100) begin tests_failed++; $display("FAIL single_re: got %b expected 0100", read_enable); end
        fifo_empty = '1;
        @(negedge clk);
        tests_run++;
        if (read_enable !== 4'b0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_cap: got re=%b v=%b expected 0000 0", read_enable, out_valid); end
        @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 12'hA5C || out_channel !== 2'd2 || e.ch !== 2'd2) begin
            tests_failed++; $display("FAIL single_word: got v=%b d=%h ch=%0d expected 1 a5c 2", out_valid, out_data, out_channel);
        end
        m_count++;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || read_enable !== 4'b0 || xfer_count !== CW'(m_count)) begin
            tests_failed++; $display("FAIL single_done: got v=%b re=%b cnt=%0d expected 0 0000 %0d", out_valid, read_enable, xfer_count, m_count % 16);
        end
    endtask

    task automatic test_hold_stall();
        exp_t e;
        fifo_empty = '0; out_ready = 1'b0;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h3C0 + n);
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== oh(sb[0].ch)) begin tests_failed++; $display("FAIL hold_re: got %b expected %b", read_enable, oh(sb[0].ch)); end
        fifo_empty = '1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== sb[0].data || out_channel !== sb[0].ch) begin
            tests_failed++; $display("FAIL hold_first: got v=%b d=%h ch=%0d expected 1 %h %0d", out_valid, out_data, out_channel, sb[0].data, sb[0].ch);
        end
        for (int n = 0; n < 4; n++) dat[n] = 12'hFFF;
        repeat (10) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== sb[0].data || out_channel !== sb[0].ch ||
                read_enable !== 4'b0 || xfer_count !== CW'(m_count)) begin
                tests_failed++;
                $display("FAIL hold_stable: got v=%b d=%h ch=%0d re=%b cnt=%0d expected 1 %h %0d 0000 %0d",
                         out_valid, out_data, out_channel, read_enable, xfer_count, sb[0].data, sb[0].ch, m_count % 16);
            end
        end
        out_ready = 1'b1;
        #1;
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== e.data) begin tests_failed++; $display("FAIL hold_release: got v=%b d=%h expected 1 %h", out_valid, out_data, e.data); end
        m_count++;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || xfer_count !== CW'(m_count)) begin
            tests_failed++; $display("FAIL hold_count: got v=%b cnt=%0d expected 0 %0d", out_valid, xfer_count, m_count % 16);
        end
    endtask

    task automatic test_af_priority();
        exp_t e;
        fifo_empty = '0; fifo_almost_full = 4'b1000; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h200 + n);
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== AF_FIRST_RE || read_enable !== oh(sb[0].ch)) begin
            tests_failed++; $display("FAIL af_first: got %b expected %b", read_enable, AF_FIRST_RE);
        end
        fifo_almost_full = '0;
        push_grant();
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
            tests_failed++; $display("FAIL af_word1: got v=%b ch=%0d d=%h expected 1 %0d %h", out_valid, out_channel, out_data, e.ch, e.data);
        end
        m_count++;
        repeat (2) @(negedge clk);
        tests_run++;
        if (read_enable !== AF_SECOND_RE || read_enable !== oh(sb[0].ch)) begin
            tests_failed++; $display("FAIL af_second: got %b expected %b", read_enable, AF_SECOND_RE);
        end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
            tests_failed++; $display("FAIL af_word2: got v=%b ch=%0d d=%h expected 1 %0d %h", out_valid, out_channel, out_data, e.ch, e.data);
        end
        m_count++;
        fifo_empty = '1;
        @(negedge clk);
        tests_run++;
        if (xfer_count !== CW'(m_count)) begin tests_failed++; $display("FAIL af_count: got %0d expected %0d", xfer_count, m_count % 16); end
    endtask

    task automatic test_freeze_resume();
        exp_t e;
        logic [3:0] exp_re;
        fifo_empty = '0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h4A0 + n);
        push_grant();
        exp_re = oh(sb[0].ch);
        @(negedge clk);
        tests_run++;
        if (read_enable !== exp_re) begin tests_failed++; $display("FAIL frz_re: got %b expected %b", read_enable, exp_re); end
        Enable = 1'b0; fifo_empty = '1;
        #1;
        tests_run++;
        if (read_enable !== 4'b0) begin tests_failed++; $display("FAIL frz_mask: got %b expected 0000", read_enable); end
        repeat (3) begin
            @(negedge clk);
            tests_run++;
            if (read_enable !== 4'b0 || out_valid !== 1'b0 || xfer_count !== CW'(m_count)) begin
                tests_failed++; $display("FAIL frz_hold: got re=%b v=%b cnt=%0d expected 0000 0 %0d", read_enable, out_valid, xfer_count, m_count % 16);
            end
        end
        Enable = 1'b1;
        #1;
        tests_run++;
        if (read_enable !== exp_re) begin tests_failed++; $display("FAIL frz_resume: got %b expected %b", read_enable, exp_re); end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
            tests_failed++; $display("FAIL frz_word: got v=%b ch=%0d d=%h expected 1 %0d %h", out_valid, out_channel, out_data, e.ch, e.data);
        end
        m_count++;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || xfer_count !== CW'(m_count)) begin
            tests_failed++; $display("FAIL frz_count: got v=%b cnt=%0d expected 0 %0d", out_valid, xfer_count, m_count % 16);
        end
    endtask

    task automatic test_reset_discard();
        exp_t e;
        fifo_empty = '0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h5B0 + n);
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== oh(sb[0].ch)) begin tests_failed++; $display("FAIL rst_re: got %b expected %b", read_enable, oh(sb[0].ch)); end
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_channel !== 2'd0 || xfer_count !== '0 || read_enable !== 4'b0) begin
            tests_failed++;
            $display("FAIL rst_discard: got v=%b d=%h ch=%0d cnt=%0d re=%b expected all 0", out_valid, out_data, out_channel, xfer_count, read_enable);
        end
        Reset = 1'b0;
        m_rr = 2'd0; m_count = 0; sb.delete();
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== 4'b0001) begin tests_failed++; $display("FAIL rst_ptr: got %b expected 0001", read_enable); end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
            tests_failed++; $display("FAIL rst_word: got v=%b ch=%0d d=%h expected 1 %0d %h", out_valid, out_channel, out_data, e.ch, e.data);
        end
        m_count++;
        fifo_empty = '1;
        @(negedge clk);
        tests_run++;
        if (xfer_count !== CW'(m_count)) begin tests_failed++; $display("FAIL rst_count: got %0d expected %0d", xfer_count, m_count % 16); end
    endtask

    task automatic test_wrap_search();
        exp_t e;
        fifo_empty = 4'b1110; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'(12'h6D0 + n);
        push_grant();
        @(negedge clk);
        tests_run++;
        if (read_enable !== 4'b0001 || sb[0].ch !== 2'd0) begin tests_failed++; $display("FAIL wrap_re: got %b expected 0001", read_enable); end
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        tests_run++;
        if (out_valid !== 1'b1 || out_channel !== e.ch || out_data !== e.data) begin
            tests_failed++; $display("FAIL wrap_word: got v=%b ch=%0d d=%h expected 1 %0d %h", out_valid, out_channel, out_data, e.ch, e.data);
        end
        m_count++;
        fifo_empty = '1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] exp_re;
        fifo_empty = '0; out_ready = 1'b1;
        for (int n = 0; n < 4; n++) dat[n] = 12'($urandom_range(0, 4095));
        repeat (16) push_grant();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            exp_re = ((k % 4) == 1 && sb.size() != 0) ? oh(sb[0].ch) : 4'b0;
            tests_run++;
            if (read_enable !== exp_re || xfer_count !== CW'(m_count)) begin
                tests_failed++; $display("FAIL b2b k=%0d: got re=%b cnt=%0d expected %b %0d", k, read_enable, xfer_count, exp_re, m_count % 16);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                tests_run++;
                if (out_channel !== e.ch || out_data !== e.data) begin
                    tests_failed++; $display("FAIL b2b_word: got ch=%0d d=%h expected ch=%0d d=%h", out_channel, out_data, e.ch, e.data);
                end
                m_count++;
                if (k == 63) fifo_empty = '1;
            end
        end
        @(negedge clk);
        tests_run++;
        if (xfer_count !== CW'(m_count) || sb.size() != 0) begin
            tests_failed++; $display("FAIL b2b_end: got cnt=%0d left=%0d expected %0d 0", xfer_count, sb.size(), m_count % 16);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_channel();
        test_hold_stall();
        test_af_priority();
        test_freeze_resume();
        test_reset_discard();
        test_wrap_search();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
